mem_dispatch_sequencer: RTL

MEM_DISPATCH_SEQUENCER -- requirements
Module: mem_dispatch_sequencer

---
 rtl/mem_dispatch_sequencer.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/mem_dispatch_sequencer.sv
// mem_dispatch_sequencer: dual-lane dispatch FIFO feeding one LSU port.
// Define MEMSEQ_CDB_WAKEUP_EN to let queued stores capture store data from the CDB.
module mem_dispatch_sequencer #(
    parameter int DEPTH  = 4,
    parameter int XLEN   = 32,
    parameter int PHYS_W = 6,
    parameter int ROB_W  = 6
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        flush_pipeline,
    input  logic [1:0]                  in_valid,
    input  logic [1:0]                  in_is_load,
    input  logic [1:0][7:0]             in_opcode,
    input  logic [1:0][XLEN-1:0]        in_base,
    input  logic [1:0][XLEN-1:0]        in_offset,
    input  logic [1:0][PHYS_W-1:0]      in_phys_rd,
    input  logic [1:0][ROB_W-1:0]       in_rob_idx,
    input  logic [1:0][XLEN-1:0]        in_sdata,
    input  logic [1:0]                  in_sdata_ready,
    input  logic [1:0][PHYS_W-1:0]      in_sdata_tag,
    output logic                        in_ready,
    input  logic [1:0]                  cdb_valid,
    input  logic [1:0][PHYS_W-1:0]      cdb_tag,
    input  logic [1:0][XLEN-1:0]        cdb_value,
    output logic                        lsu_valid,
    input  logic                        lsu_ready,
    output logic                        lsu_is_load,
    output logic [7:0]                  lsu_opcode,
    output logic [XLEN-1:0]             lsu_base_addr,
    output logic [XLEN-1:0]             lsu_offset,
    output logic [PHYS_W-1:0]           lsu_phys_rd,
    output logic [ROB_W-1:0]            lsu_rob_idx,
    output logic [XLEN-1:0]             lsu_store_data_val,
    output logic                        lsu_store_data_ready,
    output logic [$clog2(DEPTH):0]      occupancy
);
    localparam int AW = $clog2(DEPTH);

    logic              r_is_load [DEPTH];
    logic [7:0]        r_opcode  [DEPTH];
    logic [XLEN-1:0]   r_base    [DEPTH];
    logic [XLEN-1:0]   r_offset  [DEPTH];
    logic [PHYS_W-1:0] r_rd      [DEPTH];
    logic [ROB_W-1:0]  r_rob     [DEPTH];
    logic [XLEN-1:0]   r_sdata   [DEPTH];
    logic              r_srdy    [DEPTH];
    logic [AW-1:0]     r_head, r_tail;
    logic [AW:0]       r_count;

    logic [1:0]            w_enq;
    logic                  w_deq, w_ne, w_block;
    logic [AW-1:0]         w_slot [2];
    logic [1:0][XLEN-1:0]  w_in_sdata;
    logic [1:0]            w_in_srdy;

    assign w_ne      = r_count != '0;
    assign in_ready  = (r_count <= (AW+1)'(DEPTH - 2)) && !flush_pipeline;
    assign w_enq     = in_valid & {2{in_ready}};
    assign lsu_valid = w_ne && !flush_pipeline && !w_block;
    assign w_deq     = lsu_valid && lsu_ready;
    assign w_slot[0] = r_tail;
    assign w_slot[1] = r_tail + AW'(w_enq[0]);
    assign occupancy = r_count;

    assign lsu_is_load          = w_ne && r_is_load[r_head];
    assign lsu_opcode           = w_ne ? r_opcode[r_head] : '0;
    assign lsu_base_addr        = w_ne ? r_base[r_head]   : '0;
    assign lsu_offset           = w_ne ? r_offset[r_head] : '0;
    assign lsu_phys_rd          = w_ne ? r_rd[r_head]     : '0;
    assign lsu_rob_idx          = w_ne ? r_rob[r_head]    : '0;
    assign lsu_store_data_val   = w_ne ? r_sdata[r_head]  : '0;
    assign lsu_store_data_ready = w_ne && r_srdy[r_head];

`ifdef MEMSEQ_CDB_WAKEUP_EN
    logic [PHYS_W-1:0] r_stag [DEPTH];

    assign w_block = w_ne && !r_is_load[r_head] && !r_srdy[r_head];

    // Later CDB lane overrides earlier, giving cdb[1] priority on a dual match.
    always_comb begin
        for (int l = 0; l < 2; l++) begin
            w_in_sdata[l] = in_sdata[l];
            w_in_srdy[l]  = in_sdata_ready[l];
            if (!in_is_load[l] && !in_sdata_ready[l])
                for (int c = 0; c < 2; c++)
                    if (cdb_valid[c] && cdb_tag[c] == in_sdata_tag[l]) begin
                        w_in_sdata[l] = cdb_value[c];
                        w_in_srdy[l]  = 1'b1;
                    end
        end
    end
`else
    logic w_unused;

    assign w_block    = 1'b0;
    assign w_in_sdata = in_sdata;
    assign w_in_srdy  = in_sdata_ready;
    assign w_unused   = ^{cdb_valid, cdb_tag, cdb_value, in_sdata_tag};
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) r_srdy[i] <= 1'b0;
        end else if (flush_pipeline) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
`ifdef MEMSEQ_CDB_WAKEUP_EN
            for (int i = 0; i < DEPTH; i++)
                if (!r_is_load[i] && !r_srdy[i])
                    for (int c = 0; c < 2; c++)
                        if (cdb_valid[c] && cdb_tag[c] == r_stag[i]) begin
                            r_sdata[i] <= cdb_value[c];
                            r_srdy[i]  <= 1'b1;
                        end
`endif
            for (int l = 0; l < 2; l++)
                if (w_enq[l]) begin
                    r_is_load[w_slot[l]] <= in_is_load[l];
                    r_opcode[w_slot[l]]  <= in_opcode[l];
                    r_base[w_slot[l]]    <= in_base[l];
                    r_offset[w_slot[l]]  <= in_offset[l];
                    r_rd[w_slot[l]]      <= in_phys_rd[l];
                    r_rob[w_slot[l]]     <= in_rob_idx[l];
                    r_sdata[w_slot[l]]   <= w_in_sdata[l];
                    r_srdy[w_slot[l]]    <= w_in_srdy[l];
`ifdef MEMSEQ_CDB_WAKEUP_EN
                    r_stag[w_slot[l]]    <= in_sdata_tag[l];
`endif
                end
            r_tail  <= r_tail + AW'(w_enq[0]) + AW'(w_enq[1]);
            r_head  <= r_head + AW'(w_deq);
            r_count <= r_count + (AW+1)'(w_enq[0]) + (AW+1)'(w_enq[1]) - (AW+1)'(w_deq);
        end
    end
endmodule
